// File: rtl/mmc1_serial_writer.sv
// ============================================================================
// Module      : mmc1_serial_writer
// Description : CPU-side bus master that serialises 5-bit MMC1 register loads
//               (and the D7 shift-register reset) onto the cartridge bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmc1_serial_writer #(
    parameter int M2_LOW_CLKS     = 3,
    parameter int M2_HIGH_CLKS    = 3,
    parameter int ROMSEL_DLY_CLKS = 1,
    parameter int GAP_CYCLES      = 1
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_RESET,
    input  logic [1:0] CMD_REG,
    input  logic [4:0] CMD_DATA,
    output logic       DONE,
    output logic       CPU_M2,
    output logic       nCPU_ROMSEL,
    output logic       nCPU_RW,
    output logic       CPU_A13,
    output logic       CPU_A14,
    output logic       CPU_D0,
    output logic       CPU_D7
);

    localparam int c_cyc_clks = M2_LOW_CLKS + M2_HIGH_CLKS;
    localparam int c_ph_w     = $clog2(c_cyc_clks);
    localparam int c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_ph_w-1:0]  c_ph_last    = c_ph_w'(c_cyc_clks - 1);
    localparam logic [c_ph_w-1:0]  c_ph_m2_rise = c_ph_w'(M2_LOW_CLKS);
    localparam logic [c_ph_w-1:0]  c_ph_sel     = c_ph_w'(M2_LOW_CLKS + ROMSEL_DLY_CLKS);
    localparam logic [c_gap_w-1:0] c_gap_last   = c_gap_w'(GAP_CYCLES - 1);
    localparam logic [2:0]         c_bit_last   = 3'd4;

    if (M2_LOW_CLKS < 1) begin : g_chk_low
        $error("M2_LOW_CLKS must be at least 1");
    end
    if (M2_HIGH_CLKS < 2) begin : g_chk_high
        $error("M2_HIGH_CLKS must be at least 2");
    end
    if (ROMSEL_DLY_CLKS < 1 || ROMSEL_DLY_CLKS >= M2_HIGH_CLKS) begin : g_chk_dly
        $error("ROMSEL_DLY_CLKS must be in 1..M2_HIGH_CLKS-1");
    end
    if (GAP_CYCLES < 1) begin : g_chk_gap
        $error("GAP_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_ph_w-1:0]    phase_q, phase_d;
    logic [2:0]           bit_q, bit_d;
    logic [c_gap_w-1:0]   gap_q, gap_d;
    logic                 cmd_rst_q, cmd_rst_d;
    logic [1:0]           reg_q, reg_d;
    logic [4:0]           data_q, data_d;

    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 m2_q, m2_d;
    logic                 romsel_n_q, romsel_n_d;
    logic                 rw_n_q, rw_n_d;
    logic                 d0_q, d0_d;
    logic                 d7_q, d7_d;
    logic [1:0]           addr_q, addr_d;

    logic                 w_accept;
    logic                 w_cyc_end;

    assign w_accept  = CMD_VALID && ready_q;
    assign w_cyc_end = (phase_q == c_ph_last);

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            cmd_rst_q  <= 1'b0;
            reg_q      <= '0;
            data_q     <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            m2_q       <= 1'b0;
            romsel_n_q <= 1'b1;
            rw_n_q     <= 1'b1;
            d0_q       <= 1'b0;
            d7_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            cmd_rst_q  <= cmd_rst_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            m2_q       <= m2_d;
            romsel_n_q <= romsel_n_d;
            rw_n_q     <= rw_n_d;
            d0_q       <= d0_d;
            d7_q       <= d7_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        cmd_rst_d = cmd_rst_q;
        reg_d     = reg_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d   = S_WR;
                    phase_d   = '0;
                    bit_d     = '0;
                    gap_d     = '0;
                    cmd_rst_d = CMD_RESET;
                    reg_d     = CMD_REG;
                    data_d    = CMD_DATA;
                end
            end
            S_WR: begin
                phase_d = w_cyc_end ? '0 : phase_q + 1'b1;
                if (w_cyc_end) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                phase_d = w_cyc_end ? '0 : phase_q + 1'b1;
                if (w_cyc_end) begin
                    if (gap_q != c_gap_last) begin
                        gap_d = gap_q + 1'b1;
                    end else if (cmd_rst_q || bit_q == c_bit_last) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WR;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus pins are a registered image of the sequencer state, so they lag it by
    // one clock and never glitch; DONE/READY share that same output stage.
    always_comb begin
        busy_d     = (state_q != S_IDLE);
        ready_d    = (state_q == S_IDLE) && !w_accept;
        done_d     = (state_q == S_IDLE) && busy_q;
        m2_d       = busy_d && (phase_q >= c_ph_m2_rise);
        romsel_n_d = !((state_q == S_WR) && (phase_q >= c_ph_sel));
        rw_n_d     = (state_q != S_WR);
        d0_d       = (state_q == S_WR) && !cmd_rst_q && data_q[bit_q];
        d7_d       = (state_q == S_WR) && cmd_rst_q;
        addr_d     = reg_q;
    end

    assign CMD_READY   = ready_q;
    assign DONE        = done_q;
    assign CPU_M2      = m2_q;
    assign nCPU_ROMSEL = romsel_n_q;
    assign nCPU_RW     = rw_n_q;
    assign CPU_A13     = addr_q[0];
    assign CPU_A14     = addr_q[1];
    assign CPU_D0      = d0_q;
    assign CPU_D7      = d7_q;

endmodule

`default_nettype wire

// File: tb/tb_mmc1_serial_writer.sv
// ============================================================================
// Module      : tb_mmc1_serial_writer
// Description : Scoreboard bench with an MMC1 receiver model on two DUT
//               instances (default timing and a fast parameter set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mmc1_serial_writer;

    localparam int PL [2] = '{3, 1};
    localparam int PH [2] = '{3, 2};
    localparam int PD [2] = '{1, 1};
    localparam int PG [2] = '{1, 2};

    typedef struct {
        int         inst;
        int         t;
        logic [1:0] a;
        logic       d0;
        logic       d7;
    } wr_t;

    typedef struct {
        int inst;
        int t;
    } dn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid [2];
    logic       cmd_reset;
    logic [1:0] cmd_reg;
    logic [4:0] cmd_data;
    logic       ready [2], done [2], m2 [2], romsel [2], rw [2];
    logic       a13 [2], a14 [2], d0 [2], d7 [2];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  n_wr     = 0;
    int  n_done [2];
    int  last_fall [2];
    logic prev_rs [2];
    logic [4:0] sr [2], ctrl [2], chr0 [2], chr1 [2], prg [2];
    wr_t wq [$];
    dn_t dq [$];

    mmc1_serial_writer #(
        .M2_LOW_CLKS(3), .M2_HIGH_CLKS(3), .ROMSEL_DLY_CLKS(1), .GAP_CYCLES(1)
    ) u_dut0 (
        .SYS_CLK(clk), .SYS_RST(rst), .CMD_VALID(valid[0]), .CMD_READY(ready[0]),
        .CMD_RESET(cmd_reset), .CMD_REG(cmd_reg), .CMD_DATA(cmd_data), .DONE(done[0]),
        .CPU_M2(m2[0]), .nCPU_ROMSEL(romsel[0]), .nCPU_RW(rw[0]), .CPU_A13(a13[0]),
        .CPU_A14(a14[0]), .CPU_D0(d0[0]), .CPU_D7(d7[0])
    );

    mmc1_serial_writer #(
        .M2_LOW_CLKS(1), .M2_HIGH_CLKS(2), .ROMSEL_DLY_CLKS(1), .GAP_CYCLES(2)
    ) u_dut1 (
        .SYS_CLK(clk), .SYS_RST(rst), .CMD_VALID(valid[1]), .CMD_READY(ready[1]),
        .CMD_RESET(cmd_reset), .CMD_REG(cmd_reg), .CMD_DATA(cmd_data), .DONE(done[1]),
        .CPU_M2(m2[1]), .nCPU_ROMSEL(romsel[1]), .nCPU_RW(rw[1]), .CPU_A13(a13[1]),
        .CPU_A14(a14[1]), .CPU_D0(d0[1]), .CPU_D7(d7[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Receiver side: an MMC1 latching D0/D7 on the ROMSEL falling edge.
    task automatic on_write(input int i);
        int         t;
        wr_t        w;
        logic [4:0] v;
        t = cyc - 1;
        n_wr++;
        chk("wr_m2", m2[i], 1);
        chk("wr_rw", rw[i], 0);
        if (last_fall[i] >= 0)
            chk("wr_spacing", int'((t - last_fall[i]) >= 2 * (PL[i] + PH[i])), 1);
        last_fall[i] = t;
        if (wq.size() == 0) begin
            chk("wr_unexpected", 1, 0);
        end else begin
            w = wq.pop_front();
            chk("wr_inst", i, w.inst);
            chk("wr_time", t, w.t);
            chk("wr_addr", {a14[i], a13[i]}, w.a);
            chk("wr_d0", d0[i], w.d0);
            chk("wr_d7", d7[i], w.d7);
        end
        if (d7[i]) begin
            sr[i]   = 5'b10000;
            ctrl[i] = ctrl[i] | 5'b01100;
        end else if (sr[i][0]) begin
            v     = {d0[i], sr[i][4:1]};
            sr[i] = 5'b10000;
            case ({a14[i], a13[i]})
                2'b00:   ctrl[i] = v;
                2'b01:   chr0[i] = v;
                2'b10:   chr1[i] = v;
                default: prg[i]  = v;
            endcase
        end else begin
            sr[i] = {d0[i], sr[i][4:1]};
        end
    endtask

    task automatic on_done(input int i);
        dn_t d;
        n_done[i]++;
        if (dq.size() == 0) begin
            chk("done_unexpected", 1, 0);
        end else begin
            d = dq.pop_front();
            chk("done_inst", i, d.inst);
            chk("done_time", cyc - 1, d.t);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            sr[i] = 5'b10000; ctrl[i] = '0; chr0[i] = '0; chr1[i] = '0; prg[i] = '0;
            last_fall[i] = -1; prev_rs[i] = 1'b1; n_done[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    if (prev_rs[i] && !romsel[i]) on_write(i);
                    if (done[i]) on_done(i);
                end
                prev_rs[i] = romsel[i];
            end
        end
    end

    task automatic send_cmd(input int i, input logic rc, input logic [1:0] rg,
                            input logic [4:0] dt, output logic in_done);
        int  e0, per, nw;
        bit  got;
        wr_t w;
        dn_t d;
        got     = 1'b0;
        in_done = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (ready[i]) got = 1'b1;
        end
        if (!got) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        in_done   = done[i];
        cmd_reset = rc;
        cmd_reg   = rg;
        cmd_data  = dt;
        valid[i]  = 1'b1;
        @(posedge clk);
        e0 = cyc;
        #1 valid[i] = 1'b0;
        per = (1 + PG[i]) * (PL[i] + PH[i]);
        nw  = rc ? 1 : 5;
        for (int n = 0; n < nw; n++) begin
            w.inst = i;
            w.t    = e0 + 1 + n * per + PL[i] + PD[i];
            w.a    = rg;
            w.d0   = rc ? 1'b0 : dt[n];
            w.d7   = rc;
            wq.push_back(w);
        end
        d.inst = i;
        d.t    = e0 + nw * per + 1;
        dq.push_back(d);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((wq.size() != 0 || dq.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, wq.size() + dq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic f;
        int   base, dbase, k;
        valid[0] = 1'b0; valid[1] = 1'b0;
        cmd_reset = 1'b0; cmd_reg = '0; cmd_data = '0;

        #12;
        chk("rst_m2", m2[0], 0);
        chk("rst_romsel", romsel[0], 1);
        chk("rst_rw", rw[0], 1);
        chk("rst_done", done[0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready0", ready[0], 1);
        chk("post_rst_ready1", ready[1], 1);
        chk("post_rst_a13", a13[0], 0);
        chk("post_rst_a14", a14[0], 0);

        // Normal PRG load; busy-time VALID pulse and input churn must be ignored.
        send_cmd(0, 1'b0, 2'b11, 5'b10110, f);
        repeat (10) @(negedge clk);
        cmd_reset = 1'b1; cmd_reg = 2'b00; cmd_data = 5'h1F; valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        drain("prg_drain");
        chk("prg_model", prg[0], 5'b10110);

        send_cmd(0, 1'b1, 2'b00, 5'h00, f);
        drain("rstw_drain");
        chk("rstw_sr", sr[0], 5'b10000);
        chk("rstw_ctrl32", ctrl[0][3:2], 2'b11);

        // Back-to-back: second command accepted in the DONE clock of the first.
        send_cmd(0, 1'b0, 2'b01, 5'h1F, f);
        send_cmd(0, 1'b0, 2'b10, 5'h03, f);
        chk("b2b_acc_in_done", f, 1);
        drain("b2b_drain");
        chk("b2b_chr0", chr0[0], 5'h1F);
        chk("b2b_chr1", chr1[0], 5'h03);

        // Abort after the second serial write.
        base = n_wr;
        send_cmd(0, 1'b0, 2'b10, 5'h0A, f);
        k = 0;
        while (n_wr < base + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach_wr2", int'(n_wr >= base + 2), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_romsel", romsel[0], 1);
        chk("abort_m2", m2[0], 0);
        chk("abort_rw", rw[0], 1);
        chk("abort_d0", d0[0], 0);
        chk("abort_d7", d7[0], 0);
        chk("abort_a14", a14[0], 0);
        chk("abort_done", done[0], 0);
        wq.delete();
        dq.delete();
        dbase = n_done[0];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("abort_no_done", n_done[0] - dbase, 0);
        chk("abort_ready", ready[0], 1);
        send_cmd(0, 1'b1, 2'b00, 5'h00, f);
        send_cmd(0, 1'b0, 2'b00, 5'b01100, f);
        drain("ctrl_drain");
        chk("ctrl_model", ctrl[0], 5'b01100);

        // Fast parameter set on the second instance.
        send_cmd(1, 1'b0, 2'b11, 5'b01001, f);
        drain("sweep_drain");
        chk("sweep_prg", prg[1], 5'b01001);
        send_cmd(1, 1'b1, 2'b00, 5'h00, f);
        drain("sweep_rst_drain");
        chk("sweep_ctrl32", ctrl[1][3:2], 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
